// File: rtl/rename_regfile_pkg.sv
// Shared constants for the rename register file slice.
package rename_regfile_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int TAG_W_DEF    = 4;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_SRC_DEF  = 2;
    localparam int IDX_W_DEF    = $clog2(NUM_REGS_DEF);

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
endpackage

// File: rtl/rename_regfile_rf_src_read.sv
// Per-source operand resolution: zero reg, commit forward, rename wait, or value.
module rf_src_read
    import rename_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
) (
    input  logic [IDX_W-1:0]  rs_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              busy_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              cm_valid_i,
    input  logic [IDX_W-1:0]  cm_rd_i,
    input  logic [TAG_W-1:0]  cm_tag_i,
    input  logic [DATA_W-1:0] cm_data_i,
    output logic [DATA_W-1:0] v_o,
    output logic [TAG_W-1:0]  q_o,
    output logic              qv_o
);

    logic fwd;

    assign fwd = cm_valid_i && (cm_rd_i == rs_i) &&
                 (!busy_i || (tag_i == cm_tag_i));

    always_comb begin
        v_o  = '0;
        q_o  = '0;
        qv_o = FALSE;
        if (rs_i != '0) begin
            if (fwd) begin
                v_o = cm_data_i;
            end else begin
                v_o = value_i;
                if (busy_i) begin
                    qv_o = TRUE;
                    q_o  = tag_i;
                end
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename status, commit forwarding
// and a registered operand bundle towards the reservation station.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int NUM_SRC  = NUM_SRC_DEF,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [IDX_W-1:0]          disp_rd,
    input  logic [TAG_W-1:0]          disp_tag,
    input  logic [NUM_SRC*IDX_W-1:0]  disp_rs,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAG_W-1:0]          out_tag,
    output logic [NUM_SRC*DATA_W-1:0] out_v,
    output logic [NUM_SRC*TAG_W-1:0]  out_q,
    output logic [NUM_SRC-1:0]        out_qv,
    input  logic                      cm_valid,
    input  logic [IDX_W-1:0]          cm_rd,
    input  logic [TAG_W-1:0]          cm_tag,
    input  logic [DATA_W-1:0]         cm_data,
    input  logic                      flush
);

    logic [DATA_W-1:0] value_q [NUM_REGS];
    logic [DATA_W-1:0] value_d [NUM_REGS];
    logic [TAG_W-1:0]  tag_q   [NUM_REGS];
    logic [TAG_W-1:0]  tag_d   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    logic                      out_valid_q, out_valid_d;
    logic [TAG_W-1:0]          out_tag_q, out_tag_d;
    logic [NUM_SRC*DATA_W-1:0] out_v_q, out_v_d;
    logic [NUM_SRC*TAG_W-1:0]  out_q_q, out_q_d;
    logic [NUM_SRC-1:0]        out_qv_q, out_qv_d;

    logic [NUM_SRC*DATA_W-1:0] src_v;
    logic [NUM_SRC*TAG_W-1:0]  src_q;
    logic [NUM_SRC-1:0]        src_qv;

    logic fire;
    logic cm_we;
    logic disp_we;

    assign disp_ready = !rst && rdy && !flush && (!out_valid_q || out_ready);
    assign fire       = disp_valid && disp_ready;
    assign cm_we      = cm_valid && (cm_rd != '0);
    assign disp_we    = fire && (disp_rd != '0);

    // Sources see the mapping from before this instruction's own rd rename.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        logic [IDX_W-1:0] rs;
        assign rs = disp_rs[k*IDX_W +: IDX_W];

        rf_src_read #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .IDX_W  (IDX_W)
        ) u_rd (
            .rs_i       (rs),
            .value_i    (value_q[rs]),
            .busy_i     (busy_q[rs]),
            .tag_i      (tag_q[rs]),
            .cm_valid_i (cm_valid),
            .cm_rd_i    (cm_rd),
            .cm_tag_i   (cm_tag),
            .cm_data_i  (cm_data),
            .v_o        (src_v[k*DATA_W +: DATA_W]),
            .q_o        (src_q[k*TAG_W +: TAG_W]),
            .qv_o       (src_qv[k])
        );
    end

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (cm_we) begin
            value_d[cm_rd] = cm_data;
            if (tag_q[cm_rd] == cm_tag) begin
                busy_d[cm_rd] = FALSE;
            end
        end
        // A same-rd dispatch overrides the commit's busy clear.
        if (disp_we) begin
            busy_d[disp_rd] = TRUE;
            tag_d[disp_rd]  = disp_tag;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_v_d     = out_v_q;
        out_q_d     = out_q_q;
        out_qv_d    = out_qv_q;
        if (flush) begin
            out_valid_d = FALSE;
            out_v_d     = '0;
            out_q_d     = '0;
            out_qv_d    = '0;
        end else if (fire) begin
            out_valid_d = TRUE;
            out_tag_d   = disp_tag;
            out_v_d     = src_v;
            out_q_d     = src_q;
            out_qv_d    = src_qv;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = FALSE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q      <= '0;
            out_valid_q <= FALSE;
            out_tag_q   <= '0;
            out_v_q     <= '0;
            out_q_q     <= '0;
            out_qv_q    <= '0;
        end else if (rdy) begin
            value_q     <= value_d;
            tag_q       <= tag_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_v_q     <= out_v_d;
            out_q_q     <= out_q_d;
            out_qv_q    <= out_qv_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_v     = out_v_q;
    assign out_q     = out_q_q;
    assign out_qv    = out_qv_q;

endmodule
